// File: rtl/ifetch_sram_like.sv
// Pre-IF/IF fetch front end on an sram-like instruction bus.
// One request in flight, IF register plus a one-entry skid buffer.
module ifetch_sram_like #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [31:0] if_to_id_pc,
    output logic [31:0] if_to_id_inst,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_STALL
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        discard;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        sb_valid;
    logic [31:0] sb_pc;
    logic [31:0] sb_inst;

    logic xfer;
    logic if_free;

    assign xfer    = if_valid & id_allowin;
    assign if_free = ~if_valid | xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            discard  <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= '0;
            sb_valid <= 1'b0;
            sb_pc    <= '0;
            sb_inst  <= '0;
        end else begin
            if (xfer)
                if_valid <= 1'b0;
            unique case (state)
                S_REQ: begin
                    if (inst_addr_ok) begin
                        state <= S_WAIT;
                        if (br_taken) begin
                            discard <= 1'b1;
                        end else begin
                            req_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        state <= S_REQ;
                        if (discard) begin
                            discard <= 1'b0;
                        end else if (!br_taken) begin
                            if (if_free) begin
                                if_valid <= 1'b1;
                                if_pc    <= req_pc;
                                if_inst  <= inst_rdata;
                            end else begin
                                sb_valid <= 1'b1;
                                sb_pc    <= req_pc;
                                sb_inst  <= inst_rdata;
                                state    <= S_STALL;
                            end
                        end
                    end else if (br_taken) begin
                        discard <= 1'b1;
                    end
                end
                S_STALL: begin
                    if (br_taken) begin
                        state <= S_REQ;
                    end else if (xfer && sb_valid) begin
                        if_valid <= 1'b1;
                        if_pc    <= sb_pc;
                        if_inst  <= sb_inst;
                        sb_valid <= 1'b0;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
            // A redirect overrides every other pc and buffer update.
            if (br_taken) begin
                fetch_pc <= br_target;
                if_valid <= 1'b0;
                sb_valid <= 1'b0;
            end
        end
    end

    assign inst_req       = (state == S_REQ) & ~reset;
    assign inst_wr        = 1'b0;
    assign inst_size      = 2'b10;
    assign inst_addr      = fetch_pc;
    assign inst_wdata     = '0;
    assign if_to_id_valid = if_valid & ~reset;
    assign if_to_id_pc    = reset ? '0 : if_pc;
    assign if_to_id_inst  = reset ? '0 : if_inst;

endmodule

// File: tb/tb_ifetch_sram_like.sv
// Bench for ifetch_sram_like: directed vector table plus random bus,
// back-pressure and redirect traffic against a PC-stream scoreboard.
module tb_ifetch_sram_like;

    localparam logic [31:0] B = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_allowin;
    logic        if_to_id_valid;
    logic [31:0] if_to_id_pc;
    logic [31:0] if_to_id_inst;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    always #5 clk = ~clk;

    ifetch_sram_like #(.RESET_PC(B)) dut (
        .clk           (clk),
        .reset         (reset),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .id_allowin    (id_allowin),
        .if_to_id_valid(if_to_id_valid),
        .if_to_id_pc   (if_to_id_pc),
        .if_to_id_inst (if_to_id_inst),
        .inst_req      (inst_req),
        .inst_wr       (inst_wr),
        .inst_size     (inst_size),
        .inst_addr     (inst_addr),
        .inst_wdata    (inst_wdata),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata)
    );

    typedef struct {
        bit          rst;
        bit          al;
        bit          br;
        logic [31:0] tgt;
        int          lat;
        bit          ev;
        logic [31:0] epc;
        bit          er;
        logic [31:0] ea;
    } vec_t;

    vec_t vq[$];

    int n_chk  = 0;
    int n_fail = 0;
    int xfers  = 0;

    bit          pending = 0;
    bit          hs      = 0;
    logic [31:0] pa      = '0;
    logic [31:0] hs_addr = '0;
    int          cnt     = 0;
    int          hs_lat  = 1;
    int          cur_lat = 1;
    logic [31:0] exp_pc  = B;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic add(input bit rst, input bit al, input bit br,
                       input logic [31:0] tgt, input int lat,
                       input bit ev, input logic [31:0] epc,
                       input bit er, input logic [31:0] ea);
        vq.push_back('{rst, al, br, tgt, lat, ev, epc, er, ea});
    endtask

    task automatic rst3();
        repeat (3) add(1, 1, 0, 0, 1, 0, 0, 0, 0);
    endtask

    // Slave: addr_ok handshake, data_ok exactly lat cycles later, rdata=~addr.
    task automatic drive(input bit rst, input bit al, input bit br,
                         input logic [31:0] tgt, input int lat,
                         input int okpct);
        if (rst) begin
            pending = 0;
        end else begin
            if (inst_data_ok)
                pending = 0;
            if (hs) begin
                pending = 1;
                pa      = hs_addr;
                cnt     = hs_lat - 1;
            end else if (pending && cnt > 0) begin
                cnt--;
            end
        end
        hs           = 0;
        reset        = rst;
        id_allowin   = al;
        br_taken     = br;
        br_target    = tgt;
        cur_lat      = lat;
        inst_data_ok = !rst && pending && cnt == 0;
        inst_rdata   = inst_data_ok ? ~pa : $urandom;
        #1;
        inst_addr_ok = inst_req && ($urandom_range(99) < okpct);
    endtask

    // Scoreboard: ID must see a gapless +4 stream restarting at each redirect.
    task automatic observe();
        @(negedge clk);
        if (inst_addr_ok && inst_req) begin
            hs      = 1;
            hs_addr = inst_addr;
            hs_lat  = cur_lat;
        end
        if (pending)
            chk("one_outstanding_req", 32'(inst_req), 32'd0);
        chk("inst_wr", 32'(inst_wr), 32'd0);
        chk("inst_size", 32'(inst_size), 32'd2);
        chk("inst_wdata", inst_wdata, 32'd0);
        if (reset) begin
            exp_pc = B;
        end else if (br_taken) begin
            exp_pc = br_target;
        end else if (if_to_id_valid && id_allowin) begin
            xfers++;
            chk("sb_pc", if_to_id_pc, exp_pc);
            chk("sb_inst", if_to_id_inst, ~if_to_id_pc);
            exp_pc = if_to_id_pc + 32'd4;
        end
    endtask

    initial begin
        reset        = 1;
        br_taken     = 0;
        br_target    = '0;
        id_allowin   = 1;
        inst_addr_ok = 0;
        inst_data_ok = 0;
        inst_rdata   = '0;

        // zero-wait stream
        rst3();
        add(0, 1, 0, 0, 1, 0, 0,      1, B);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 1, 0, 0, 1, 1, B,      1, B + 4);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 1, 0, 0, 1, 1, B + 4,  1, B + 8);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 1, 0, 0, 1, 1, B + 8,  1, B + 12);
        // back-pressure fills IF and skid
        rst3();
        add(0, 1, 0, 0, 1, 0, 0,      1, B);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 0, 0, 0, 1, 1, B,      1, B + 4);
        repeat (5) add(0, 0, 0, 0, 1, 1, B, 0, 0);
        add(0, 1, 0, 0, 1, 1, B,      0, 0);
        add(0, 1, 0, 0, 1, 1, B + 4,  1, B + 8);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 1, 0, 0, 1, 1, B + 8,  1, B + 12);
        // redirect while a 3-cycle fetch is in WAIT
        rst3();
        add(0, 1, 0, 0, 3, 0, 0,      1, B);
        repeat (3) add(0, 1, 0, 0, 3, 0, 0, 0, 0);
        add(0, 1, 0, 0, 3, 1, B,      1, B + 4);
        add(0, 1, 1, B + 32'h100, 3, 0, 0, 0, 0);
        repeat (2) add(0, 1, 0, 0, 3, 0, 0, 0, 0);
        add(0, 1, 0, 0, 3, 0, 0,      1, B + 32'h100);
        repeat (3) add(0, 1, 0, 0, 3, 0, 0, 0, 0);
        add(0, 1, 0, 0, 3, 1, B + 32'h100, 1, B + 32'h104);
        // redirect in the addr_ok cycle
        rst3();
        add(0, 1, 0, 0, 1, 0, 0,      1, B);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 1, 0, 0, 1, 1, B,      1, B + 4);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 1, 1, B + 32'h200, 1, 1, B + 4, 1, B + 8);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 1, 0, 0, 1, 0, 0,      1, B + 32'h200);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 1, 0, 0, 1, 1, B + 32'h200, 1, B + 32'h204);
        // redirect in STALL
        rst3();
        add(0, 1, 0, 0, 1, 0, 0,      1, B);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 0, 0, 0, 1, 1, B,      1, B + 4);
        repeat (2) add(0, 0, 0, 0, 1, 1, B, 0, 0);
        add(0, 0, 1, B + 32'h300, 1, 1, B, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0,      1, B + 32'h300);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 1, 0, 0, 1, 1, B + 32'h300, 1, B + 32'h304);
        add(0, 1, 0, 0, 1, 0, 0,      0, 0);
        add(0, 1, 0, 0, 1, 1, B + 32'h304, 1, B + 32'h308);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].al, vq[i].br, vq[i].tgt,
                  vq[i].lat, 100);
            observe();
            chk("valid", 32'(if_to_id_valid), 32'(vq[i].ev));
            chk("req", 32'(inst_req), 32'(vq[i].er));
            if (vq[i].rst) begin
                chk("rst_pc", if_to_id_pc, 32'd0);
                chk("rst_inst", if_to_id_inst, 32'd0);
            end else if (vq[i].ev) begin
                chk("pc", if_to_id_pc, vq[i].epc);
                chk("inst", if_to_id_inst, ~vq[i].epc);
            end
            if (vq[i].er)
                chk("addr", inst_addr, vq[i].ea);
            @(posedge clk);
            #1;
        end

        begin
            int rst_left = 0;
            for (int c = 0; c < 4000; c++) begin
                bit r;
                if (rst_left == 0 && $urandom_range(599) == 0)
                    rst_left = 2;
                r = rst_left > 0;
                if (rst_left > 0)
                    rst_left--;
                drive(r, $urandom_range(99) < 70,
                      $urandom_range(99) < 5,
                      $urandom & 32'hffff_fffc,
                      $urandom_range(4, 1), 50);
                observe();
                @(posedge clk);
                #1;
            end
        end

        chk("enough_transfers", 32'(xfers >= 150), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_sram_like.md
# ifetch_sram_like

Pre-IF/IF front end for the pipelined LoongArch core. It replaces the fixed-latency synchronous instruction-SRAM port with a variable-latency sram-like request/response bus (`req`/`addr_ok`/`data_ok`). It owns the fetch PC and keeps at most one request outstanding. It buffers up to two fetched instructions against ID back-pressure, and drops in-flight or buffered fetches when ID redirects on a taken branch. Its output feeds the ID pipeline register.

## Interface
Parameters:
- `RESET_PC`, default `32'h1c000000`, first fetch address after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `br_taken`  in  1  redirect from ID, already qualified with ID valid and no stall.
- `br_target`  in  32  redirect address, valid when `br_taken`.
- `id_allowin`  in  1  ID accepts `if_to_id_*` this cycle.
- `if_to_id_valid`  out  1  IF register holds a valid instruction.
- `if_to_id_pc`  out  32  PC of the held instruction.
- `if_to_id_inst`  out  32  held instruction word.
- `inst_req`  out  1  fetch request.
- `inst_wr`  out  1  constant 0.
- `inst_size`  out  2  constant `2'b10` (word).
- `inst_addr`  out  32  fetch address, equals `fetch_pc`.
- `inst_wdata`  out  32  constant 0.
- `inst_addr_ok`  in  1  request accepted this cycle.
- `inst_data_ok`  in  1  response valid this cycle.
- `inst_rdata`  in  32  response word.

## Operation
State registers:
- `fetch_pc`.
- `req_pc`: PC of the accepted request.
- `discard`: drop the next response.
- IF register (`if_valid`/`if_pc`/`if_inst`).
- Skid buffer (`sb_valid`/`sb_pc`/`sb_inst`).
- FSM: REQ, WAIT, STALL.

Bus rules:
- Single outstanding request.
- `inst_req` = (state==REQ) & ~reset.
- The bus permits `inst_addr` to change while `inst_req` is high before `addr_ok`.
- `data_ok` arrives no earlier than the cycle after `addr_ok`.

Transfer and consumption:
- Transfer to ID = `if_valid & id_allowin`.
- "IF free" = `~if_valid` or a transfer this cycle.

REQ:
- `addr_ok` & ~`br_taken`: `req_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4 (32-bit wrap), go WAIT.
- `addr_ok` & `br_taken`: `fetch_pc`<=`br_target`, `discard`<=1, go WAIT.
- ~`addr_ok` & `br_taken`: `fetch_pc`<=`br_target`, stay REQ.

WAIT:
- `data_ok` with `discard`: clear `discard`, drop the word, go REQ.
- `data_ok` with `br_taken` (`discard`=0): drop the word, go REQ.
- `data_ok` otherwise, IF free: IF<={`req_pc`,`rdata`}, go REQ.
- `data_ok` otherwise, IF not free: skid<={`req_pc`,`rdata`}, go STALL.
- ~`data_ok` & `br_taken`: `discard`<=1, `fetch_pc`<=`br_target`.

STALL (no request issued):
- On transfer: IF<=skid, clear `sb_valid`, go REQ.

Branch handling:
- `br_taken` in any state clears `if_valid` and `sb_valid`.
- Any concurrent transfer is ignored; ID cancels it.
- `br_taken` in STALL: `fetch_pc`<=`br_target`, go REQ.

Other IF register rules:
- A transfer with nothing arriving clears `if_valid`.
- A transfer concurrent with a response loading IF keeps `if_valid`=1 with the new contents.
- `br_taken` has priority over every other update to `fetch_pc` and the buffers.

## Timing
Reset:
- While `reset` is high: state=REQ, `fetch_pc`=`RESET_PC`, `discard`=0, `if_valid`=`sb_valid`=0.
- Outputs during reset: `inst_req`=0, `if_to_id_valid`=0, `if_to_id_pc`=0, `if_to_id_inst`=0.
- `reset` mid-transaction abandons any outstanding response; the interconnect is reset together with this block.

Latency and throughput:
- First request is asserted in the first cycle after `reset` falls, with `inst_addr`=`RESET_PC`.
- Latency from `data_ok` to `if_to_id_valid` = 1 cycle.
- Zero-wait slave (`addr_ok`=1, `data_ok` the next cycle): one instruction per 2 cycles.

Boundary conditions:
- Skid full implies no request is issued, so a response is never lost.
- No duplicated or skipped PC except on redirect.

## Test plan
- Reset held 3 cycles: `inst_req`=0 and `if_to_id_valid`=0 throughout. First cycle after release: `inst_req`=1, `inst_addr`=`0x1c000000`.
- Zero-wait slave returning `rdata`=`~addr`, `id_allowin`=1: ID sees PCs `0x1c000000`, `0x1c000004`, `0x1c000008` two cycles apart, each with inst=`~pc`.
- `id_allowin`=0 for 6 cycles starting at the first delivery: IF holds `0x1c000000`, skid holds `0x1c000004`, `inst_req` stays low. On release, PCs `0x1c000000`, `0x1c000004`, `0x1c000008` arrive in order with no gap beyond the bus latency.
- Slave with 3-cycle `data_ok` latency; `br_taken`, `br_target`=`0x1c000100` while the `0x1c000004` fetch is in WAIT. The returning word is dropped, the next `inst_addr`=`0x1c000100`, and ID next sees PC `0x1c000100`.
- `br_taken` in the same cycle as `addr_ok` for `0x1c000008`: the response is dropped and the next request goes to the target.
- `br_taken` while in STALL: IF and skid are both invalidated, `if_to_id_valid`=0 the next cycle, and the next request goes to `br_target`.
